// File: rtl/vco_meas_ctrl_pkg.sv
// Shared constants for the VCO measurement sequencer and the top-register map.
package vco_meas_ctrl_pkg;

    // Sequencer state encoding
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_WAIT = 3'd1;
    localparam logic [2:0] ST_REQ  = 3'd2;
    localparam logic [2:0] ST_REL  = 3'd3;
    localparam logic [2:0] ST_ACC  = 3'd4;
    localparam logic [2:0] ST_OUT  = 3'd5;

    // Default VCO count width
    localparam int unsigned CNT_W_DEF = 24;

    // Sticky-flag bit positions, shared with the top-register map
    localparam int unsigned STK_OOR = 0;
    localparam int unsigned STK_TMO = 1;

endpackage

// File: rtl/vco_meas_ctrl.sv
// Periodic VCO frequency-measurement sequencer: 4-phase req/ack to the tck-domain
// counter, 1/2/4/8-sample averaging, window check and sticky error flags.
module vco_meas_ctrl
    import vco_meas_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 4096,
    parameter int unsigned CNT_W       = CNT_W_DEF
) (
    input  logic             pclk,
    input  logic             presetn,
    input  logic             cfg_en,
    input  logic [15:0]      cfg_period,
    input  logic [1:0]       cfg_avg_log2,
    input  logic [CNT_W-1:0] cfg_lo,
    input  logic [CNT_W-1:0] cfg_hi,
    input  logic [1:0]       cfg_irq_msk,
    input  logic [1:0]       sticky_clr,
    output logic             meas_req,
    input  logic             meas_ack,
    input  logic [CNT_W-1:0] meas_cnt,
    output logic [CNT_W-1:0] result,
    output logic             result_vld,
    output logic             oor_sta,
    output logic             tmo_sta,
    output logic             busy,
    output logic             irq
);

    localparam int unsigned ACC_W = CNT_W + 3;
    localparam int unsigned PER_W = 16;
    localparam int unsigned SMP_W = 4;
    localparam int unsigned TMO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    logic [2:0]       state_q,      state_d;
    logic [PER_W-1:0] period_cnt_q, period_cnt_d;
    logic [TMO_W-1:0] tmo_cnt_q,    tmo_cnt_d;
    logic [CNT_W-1:0] samp_q,       samp_d;
    logic             samp_vld_q,   samp_vld_d;
    logic             abort_q,      abort_d;
    logic [ACC_W-1:0] acc_q,        acc_d;
    logic [SMP_W-1:0] smp_cnt_q,    smp_cnt_d;
    logic [CNT_W-1:0] result_q,     result_d;
    logic             result_vld_q, result_vld_d;
    logic             oor_q,        oor_d;
    logic             tmo_q,        tmo_d;
    logic             meas_req_q,   meas_req_d;
    logic             busy_q,       busy_d;

    logic [ACC_W-1:0] acc_sum;
    logic [SMP_W-1:0] avg_n;
    logic [SMP_W-1:0] smp_cnt_inc;
    logic [CNT_W-1:0] avg_res;
    logic             oor_set;
    logic             tmo_set;

    // Next-state, datapath and flag update
    always_comb begin
        state_d      = state_q;
        period_cnt_d = period_cnt_q;
        tmo_cnt_d    = tmo_cnt_q;
        samp_d       = samp_q;
        samp_vld_d   = samp_vld_q;
        abort_d      = abort_q;
        acc_d        = acc_q;
        smp_cnt_d    = smp_cnt_q;
        result_d     = result_q;
        result_vld_d = 1'b0;
        oor_set      = 1'b0;
        tmo_set      = 1'b0;

        acc_sum     = acc_q + ACC_W'(samp_q);
        avg_n       = SMP_W'(1) << cfg_avg_log2;
        smp_cnt_inc = smp_cnt_q + SMP_W'(1);
        avg_res     = CNT_W'(acc_sum >> cfg_avg_log2);

        case (state_q)
            ST_IDLE: begin
                if (cfg_en) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (!cfg_en) begin
                    state_d = ST_IDLE;
                end else if (period_cnt_q == '0) begin
                    state_d    = ST_REQ;
                    tmo_cnt_d  = '0;
                    samp_vld_d = 1'b0;
                    abort_d    = 1'b0;
                end else begin
                    period_cnt_d = period_cnt_q - PER_W'(1);
                end
            end
            ST_REQ: begin
                abort_d = abort_q | ~cfg_en;
                if (meas_ack) begin
                    samp_d     = meas_cnt;
                    samp_vld_d = 1'b1;
                    state_d    = ST_REL;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    tmo_set   = 1'b1;
                    acc_d     = '0;
                    smp_cnt_d = '0;
                    state_d   = ST_REL;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
            end
            ST_REL: begin
                abort_d = abort_q | ~cfg_en;
                if (!meas_ack) begin
                    if (abort_q || !cfg_en) state_d = ST_IDLE;
                    else if (samp_vld_q)    state_d = ST_ACC;
                    else                    state_d = ST_WAIT;
                end
            end
            ST_ACC: begin
                acc_d     = acc_sum;
                smp_cnt_d = smp_cnt_inc;
                if (smp_cnt_inc == avg_n) begin
                    result_d     = avg_res;
                    result_vld_d = 1'b1;
                    oor_set      = (avg_res < cfg_lo) || (avg_res > cfg_hi);
                    state_d      = ST_OUT;
                end else if (!cfg_en) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_OUT: begin
                acc_d     = '0;
                smp_cnt_d = '0;
                state_d   = cfg_en ? ST_WAIT : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Any return to IDLE drops a partial accumulation
        if (state_d == ST_IDLE) begin
            acc_d     = '0;
            smp_cnt_d = '0;
        end

        // Period is sampled on WAIT entry only
        if ((state_d == ST_WAIT) && (state_q != ST_WAIT)) begin
            period_cnt_d = cfg_period;
        end

        meas_req_d = (state_d == ST_REQ);
        busy_d     = (state_d != ST_IDLE);

        // Sticky flags: a set wins over a coincident clear
        oor_d = oor_set | (oor_q & ~sticky_clr[STK_OOR]);
        tmo_d = tmo_set | (tmo_q & ~sticky_clr[STK_TMO]);
    end

    // State and output registers
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q      <= ST_IDLE;
            period_cnt_q <= '0;
            tmo_cnt_q    <= '0;
            samp_q       <= '0;
            samp_vld_q   <= 1'b0;
            abort_q      <= 1'b0;
            acc_q        <= '0;
            smp_cnt_q    <= '0;
            result_q     <= '0;
            result_vld_q <= 1'b0;
            oor_q        <= 1'b0;
            tmo_q        <= 1'b0;
            meas_req_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            period_cnt_q <= period_cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
            samp_q       <= samp_d;
            samp_vld_q   <= samp_vld_d;
            abort_q      <= abort_d;
            acc_q        <= acc_d;
            smp_cnt_q    <= smp_cnt_d;
            result_q     <= result_d;
            result_vld_q <= result_vld_d;
            oor_q        <= oor_d;
            tmo_q        <= tmo_d;
            meas_req_q   <= meas_req_d;
            busy_q       <= busy_d;
        end
    end

    assign meas_req   = meas_req_q;
    assign result     = result_q;
    assign result_vld = result_vld_q;
    assign oor_sta    = oor_q;
    assign tmo_sta    = tmo_q;
    assign busy       = busy_q;

    // Level interrupt from the registered sticky flags
    assign irq = (oor_q & cfg_irq_msk[STK_OOR]) | (tmo_q & cfg_irq_msk[STK_TMO]);

endmodule

// File: doc/vco_meas_ctrl.md
# vco_meas_ctrl

Periodic VCO frequency-measurement sequencer in the pclk domain. Issues 4-phase req/ack measurement requests to the tck-domain VCO edge counter, accumulates 1/2/4/8 counts, outputs the averaged count, and checks it against a programmable window. Error flags are sticky and drive a maskable level interrupt into the top-register interrupt controller. Configuration comes from top-register output fields; results are returned to the top-register read mux.

## Interface
Parameters:
- TIMEOUT_CYC, 4096: pclk cycles allowed for meas_ack to rise after meas_req rises.
- CNT_W, 24: width of the VCO count.

Ports:
- pclk  in  1  clock.
- presetn  in  1  reset; asynchronous, active-low.
- cfg_en  in  1  level; enables periodic measurement.
- cfg_period  in  16  idle pclk cycles between measurements; 0 means back-to-back.
- cfg_avg_log2  in  2  samples per result = 2^cfg_avg_log2.
- cfg_lo  in  CNT_W  window lower bound, inclusive.
- cfg_hi  in  CNT_W  window upper bound, inclusive.
- cfg_irq_msk  in  2  bit0 enables the out-of-range interrupt; bit1 enables the timeout interrupt.
- sticky_clr  in  2  one-cycle clear pulse; bit0 clears oor_sta, bit1 clears tmo_sta.
- meas_req  out  1  level request to the counter.
- meas_ack  in  1  counter acknowledge, already synchronised to pclk.
- meas_cnt  in  CNT_W  count; stable while meas_ack=1.
- result  out  CNT_W  last averaged count.
- result_vld  out  1  one-cycle pulse when result updates.
- oor_sta  out  1  sticky out-of-window flag.
- tmo_sta  out  1  sticky ack-timeout flag.
- busy  out  1  high when the state is not IDLE.
- irq  out  1  (oor_sta & cfg_irq_msk[0]) | (tmo_sta & cfg_irq_msk[1]).

## Operation
- States:
  - IDLE: default state.
  - WAIT: period countdown.
  - REQ: meas_req=1, waiting for ack high.
  - REL: meas_req=0, waiting for ack low.
  - ACC: accumulate the sample.
  - OUT: publish the result.
- IDLE→WAIT when cfg_en=1. Entering WAIT loads period_cnt=cfg_period.
- WAIT decrements period_cnt. At 0 it goes to REQ; with cfg_period=0 that is the next cycle. If cfg_en=0 it goes straight to IDLE.
- REQ: when meas_ack=1, capture meas_cnt into samp and go to REL. If the timeout counter reaches TIMEOUT_CYC-1 first, set tmo_sta, discard the sample, clear the accumulator and sample count, and go to REL.
- REL: when meas_ack=0, go to ACC if a sample was captured, otherwise go to WAIT (or IDLE if cfg_en=0). REL has no timeout.
- ACC: acc += samp (acc is CNT_W+3 bits, no overflow possible) and smp_cnt++. If smp_cnt+1 == 2^cfg_avg_log2, go to OUT; else go to WAIT, or IDLE if cfg_en=0. Leaving for IDLE discards the partial accumulation.
- OUT:
  - result = acc >> cfg_avg_log2, truncating.
  - Pulse result_vld.
  - Set oor_sta if the new value is < cfg_lo or > cfg_hi.
  - Clear acc and smp_cnt.
  - Go to WAIT, or IDLE if cfg_en=0.
- cfg_en=0 during REQ or REL never breaks the handshake: the 4-phase sequence completes, the sample is discarded, and the block goes to IDLE.
- Config changes take effect at the next use (period at WAIT entry, avg/window at ACC/OUT). Software changes them only while busy=0.
- Sticky flags: a set in the same cycle as sticky_clr wins.
- Window with cfg_lo > cfg_hi: every result flags oor_sta.

## Timing
- Reset values: meas_req=0, result=0, result_vld=0, oor_sta=0, tmo_sta=0, busy=0, irq=0, state IDLE, counters 0.
- All outputs are registered except irq, which is combinational from the registered flags and cfg_irq_msk.
- Every state has a one-cycle transition.
- meas_req rises on the first cycle in REQ and falls on the cycle after ack is seen high.
- With 2^N samples, result_vld fires 1 cycle after the last ACC cycle. result and oor_sta are valid in the same cycle as the result_vld pulse.
- Minimum loop with cfg_period=0 and ack latency L: WAIT 1 + REQ L + REL (ack fall latency) + ACC 1.
- A reset mid-handshake drops meas_req immediately. The counter side is reset by the same presetn.

## Structure
- Shared package holds:
  - state encoding localparams: IDLE=0, WAIT=1, REQ=2, REL=3, ACC=4, OUT=5;
  - CNT_W default;
  - the sticky-flag bit indices (OOR=0, TMO=1), shared with the top-register map.
- Single module, no sub-modules.
- The tck-side counter and the 2-flop ack synchroniser stay external.

## Test plan
- Single sample, in window: cfg_avg_log2=0, cfg_period=3, cfg_lo=8000, cfg_hi=8400; ack after 5 cycles with cnt=8222 -> result=8222, one result_vld pulse, oor_sta=0, irq=0.
- Averaging: cfg_avg_log2=2; counts 100,101,102,104 -> result=101 (407>>2), exactly one result_vld per 4 handshakes.
- Out of window: cnt=9000, cfg_hi=8400, cfg_irq_msk=01 -> oor_sta=1 and irq=1 with the result_vld cycle. sticky_clr=01 clears both. A clear coinciding with a new violation leaves oor_sta=1.
- Timeout: TIMEOUT_CYC=16, ack held low -> tmo_sta=1 after 16 REQ cycles, meas_req=0, no result_vld. Ack then toggled late -> REL completes and the next measurement proceeds normally.
- Disable mid-handshake: cfg_en dropped while in REQ -> meas_req held until ack=1, then 0. busy falls after ack=0, no result_vld, and acc=0 on re-enable.
- Async reset during REQ -> meas_req=0 and all outputs at reset values in the same cycle; after release the block idles until cfg_en=1.
